// File: rtl/bus_ram_if.sv
// Request/ready bus between a CPU bus port (master) and a RAM responder (slave).
// Signals: i_request/i_rw/i_address/i_wdata driven by the initiator,
//          o_ready/o_rdata driven by the responder.
interface bus_ram_if;
    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic [31:0] o_rdata;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_ready, o_rdata
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_ready, o_rdata
    );
endinterface

// File: rtl/bus_ram.sv
// Word-addressed block-RAM responder for the CPU request/ready bus.
// Completes each access after WAIT_STATES extra cycles and holds o_ready
// until the initiator releases i_request.
// Ports:
//   i_clock             clock
//   i_reset             synchronous active-high reset
//   bus                 request/ready bus (slave side)
//   o_access_count      completed accesses since reset (wraps)
//   o_range_error_count out-of-range accesses
// Optional feature: define BUS_RAM_RANGE_CHECK_EN to drop/zero accesses whose
// word index is >= SIZE and count them; otherwise upper addresses alias.
module bus_ram #(
    parameter int unsigned SIZE        = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    bus_ram_if.slave    bus,
    output logic [31:0] o_access_count,
    output logic [31:0] o_range_error_count
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, ACCESS, READY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [29:0] idx_q, idx_d;
    logic        rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic        mem_we_c;
    logic        oor_c;
    logic [31:0] mem_rd_c;

    logic [31:0] mem [SIZE];

    // Address byte-lane bits and (without range check) upper index bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus.i_address, idx_q};

    assign mem_rd_c = mem[idx_q[IDX_W-1:0]];

`ifdef BUS_RAM_RANGE_CHECK_EN
    logic [31:0] rerr_q, rerr_d;
    assign oor_c               = {2'b00, idx_q} >= 32'(SIZE);
    assign o_range_error_count = rerr_q;
`else
    assign oor_c               = 1'b0;
    assign o_range_error_count = 32'd0;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        acc_cnt_d = acc_cnt_q;
        mem_we_c  = 1'b0;
`ifdef BUS_RAM_RANGE_CHECK_EN
        rerr_d    = rerr_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (bus.i_request) begin
                    idx_d   = bus.i_address[31:2];
                    rw_d    = bus.i_rw;
                    wdata_d = bus.i_wdata;
                    wcnt_d  = 8'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Runs to completion on captured values regardless of i_request.
                if (wcnt_q != 8'd0) begin
                    wcnt_d = wcnt_q - 8'd1;
                end else begin
                    ready_d   = 1'b1;
                    acc_cnt_d = acc_cnt_q + 32'd1;
                    state_d   = READY;
                    if (rw_q) begin
                        mem_we_c = ~oor_c;
                    end else begin
                        rdata_d = oor_c ? 32'd0 : mem_rd_c;
                    end
`ifdef BUS_RAM_RANGE_CHECK_EN
                    if (oor_c) begin
                        rerr_d = rerr_q + 32'd1;
                    end
`endif
                end
            end
            READY: begin
                ready_d = 1'b1;
                if (!bus.i_request) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            wcnt_q    <= 8'd0;
            idx_q     <= 30'd0;
            rw_q      <= 1'b0;
            wdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            acc_cnt_q <= 32'd0;
`ifdef BUS_RAM_RANGE_CHECK_EN
            rerr_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            acc_cnt_q <= acc_cnt_d;
`ifdef BUS_RAM_RANGE_CHECK_EN
            rerr_q    <= rerr_d;
`endif
        end
    end

    // RAM array: contents survive reset; a reset edge blocks the commit.
    always_ff @(posedge i_clock) begin
        if (mem_we_c && !i_reset) begin
            mem[idx_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_rdata     = rdata_q;
    assign o_access_count  = acc_cnt_q;

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: table of single transactions on a zero-wait
// instance, plus hand sequences for wait states, early release, reset abort
// and counter wrap.
module tb_bus_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_c;

    bus_ram_if ifa ();
    bus_ram_if ifb ();
    bus_ram_if ifc ();

    logic [31:0] cnt_a, rerr_a, cnt_b, rerr_b, cnt_c, rerr_c;

    bus_ram #(.SIZE(1024), .WAIT_STATES(0)) u_a (
        .i_clock(clk), .i_reset(rst), .bus(ifa),
        .o_access_count(cnt_a), .o_range_error_count(rerr_a));
    bus_ram #(.SIZE(1024), .WAIT_STATES(3)) u_b (
        .i_clock(clk), .i_reset(rst), .bus(ifb),
        .o_access_count(cnt_b), .o_range_error_count(rerr_b));
    bus_ram #(.SIZE(1024), .WAIT_STATES(4)) u_c (
        .i_clock(clk), .i_reset(rst_c), .bus(ifc),
        .o_access_count(cnt_c), .o_range_error_count(rerr_c));

`ifdef BUS_RAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_cnt;
        logic [31:0] exp_rerr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic req, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (w)
            0: begin ifa.i_request = req; ifa.i_rw = rw; ifa.i_address = addr; ifa.i_wdata = wdata; end
            1: begin ifb.i_request = req; ifb.i_rw = rw; ifb.i_address = addr; ifb.i_wdata = wdata; end
            default: begin ifc.i_request = req; ifc.i_rw = rw; ifc.i_address = addr; ifc.i_wdata = wdata; end
        endcase
    endtask

    function automatic logic get_ready(input int w);
        case (w)
            0: return ifa.o_ready;
            1: return ifb.o_ready;
            default: return ifc.o_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        case (w)
            0: return ifa.o_rdata;
            1: return ifb.o_rdata;
            default: return ifc.o_rdata;
        endcase
    endfunction

    // One full transaction; lat counts edges after the sampling edge until o_ready.
    task automatic xact(input int w, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rd, output logic fell);
        int  edges;
        logic seen;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        drive(w, 1'b1, rw, addr, wdata);
        while (!seen && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            seen = get_ready(w);
        end
        lat = seen ? edges - 1 : 999;
        rd  = get_rdata(w);
        drive(w, 1'b0, rw, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        fell = ~get_ready(w);
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        fell;

    initial begin
        rst   = 1'b1;
        rst_c = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0] = '{1'b1, 32'h0000, 32'h11111111, 32'h00000000, 32'd1,  32'd0};
        vecs[1] = '{1'b1, 32'h0010, 32'hDEADBEEF, 32'h00000000, 32'd2,  32'd0};
        vecs[2] = '{1'b0, 32'h0010, 32'h0,        32'hDEADBEEF, 32'd3,  32'd0};
        vecs[3] = '{1'b1, 32'h0014, 32'hCAFEF00D, 32'hDEADBEEF, 32'd4,  32'd0};
        vecs[4] = '{1'b0, 32'h0014, 32'h0,        32'hCAFEF00D, 32'd5,  32'd0};
        vecs[5] = '{1'b1, 32'h0013, 32'h01234567, 32'hCAFEF00D, 32'd6,  32'd0};
        vecs[6] = '{1'b0, 32'h0010, 32'h0,        32'h01234567, 32'd7,  32'd0};
        vecs[7] = '{1'b1, 32'h1000, 32'hA5A5A5A5, 32'h01234567, 32'd8,  RC ? 32'd1 : 32'd0};
        vecs[8] = '{1'b0, 32'h1000, 32'h0, RC ? 32'h00000000 : 32'hA5A5A5A5, 32'd9,  RC ? 32'd2 : 32'd0};
        vecs[9] = '{1'b0, 32'h0000, 32'h0, RC ? 32'h11111111 : 32'hA5A5A5A5, 32'd10, RC ? 32'd2 : 32'd0};

        repeat (2) @(negedge clk);
        rst   = 1'b0;
        rst_c = 1'b0;

        check("reset ready", 32'(ifa.o_ready), 32'd0);
        check("reset rdata", ifa.o_rdata, 32'd0);
        check("reset count", cnt_a, 32'd0);
        check("reset rerr",  rerr_a, 32'd0);

        // Zero-wait table
        for (int i = 0; i < 10; i++) begin
            xact(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, lat, rd, fell);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd1);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d count", i), cnt_a, vecs[i].exp_cnt);
            check($sformatf("v%0d rerr", i), rerr_a, vecs[i].exp_rerr);
            check($sformatf("v%0d ready fall", i), 32'(fell), 32'd1);
        end

        // Three wait states: latency 4, hold while requested, fall after release
        xact(1, 1'b1, 32'h0, 32'h600DCAFE, lat, rd, fell);
        check("ws3 write latency", 32'(lat), 32'd4);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            edge_step();
            check($sformatf("ws3 pre-ready e%0d", k - 1), 32'(ifb.o_ready), (k == 5) ? 32'd1 : 32'd0);
        end
        check("ws3 read rdata", ifb.o_rdata, 32'h600DCAFE);
        for (int k = 0; k < 5; k++) begin
            edge_step();
            check($sformatf("ws3 hold %0d", k), 32'(ifb.o_ready), 32'd1);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_step();
        check("ws3 fall", 32'(ifb.o_ready), 32'd0);
        check("ws3 count", cnt_b, 32'd2);

        // Request dropped during ACCESS: write still commits, one-cycle ready pulse
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        edge_step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            edge_step();
            check($sformatf("drop wait e%0d", k), 32'(ifb.o_ready), 32'd0);
        end
        edge_step();
        check("drop ready rise", 32'(ifb.o_ready), 32'd1);
        edge_step();
        check("drop ready fall", 32'(ifb.o_ready), 32'd0);
        check("drop count", cnt_b, 32'd3);
        xact(1, 1'b0, 32'h20, 32'h0, lat, rd, fell);
        check("drop readback", rd, 32'h12345678);
        check("drop readback latency", 32'(lat), 32'd4);

        // Reset while a write waits in ACCESS (wcnt=2): write discarded
        xact(2, 1'b1, 32'h40, 32'h0BADF00D, lat, rd, fell);
        check("ws4 write latency", 32'(lat), 32'd5);
        xact(2, 1'b0, 32'h40, 32'h0, lat, rd, fell);
        check("ws4 read rdata", rd, 32'h0BADF00D);
        check("ws4 count", cnt_c, 32'd2);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF);
        repeat (3) edge_step();
        rst_c = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_step();
        rst_c = 1'b0;
        check("abort ready", 32'(ifc.o_ready), 32'd0);
        check("abort rdata", ifc.o_rdata, 32'd0);
        check("abort count", cnt_c, 32'd0);
        check("abort rerr", rerr_c, 32'd0);
        repeat (6) edge_step();
        check("abort no late ready", 32'(ifc.o_ready), 32'd0);
        xact(2, 1'b0, 32'h40, 32'h0, lat, rd, fell);
        check("abort old data", rd, 32'h0BADF00D);
        check("abort next latency", 32'(lat), 32'd5);
        check("abort next count", cnt_c, 32'd1);

        // Access counter wrap
        @(negedge clk);
        force u_a.acc_cnt_q = 32'hFFFFFFFF;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        edge_step();
        release u_a.acc_cnt_q;
        check("wrap pre", cnt_a, 32'hFFFFFFFF);
        edge_step();
        check("wrap ready", 32'(ifa.o_ready), 32'd1);
        check("wrap count", cnt_a, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        edge_step();
        check("wrap fall", 32'(ifa.o_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
